// File: rtl/fir_output_buffer.sv
// Output stage of the transposed FIR chain: decimates the final tap sum and buffers kept
// samples in a first-word-fall-through FIFO with a valid/ready stream and a sticky drop flag.
module fir_output_buffer #(
  parameter int DATA_WIDTH = 24,
  parameter int DECIM      = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_sum_valid,
  input  logic signed [DATA_WIDTH-1:0]        iv_sum,
  input  logic                                i_flush,
  input  logic                                i_clr_ovf,
  input  logic                                i_ready,
  output logic                                o_valid,
  output logic signed [DATA_WIDTH-1:0]        ov_data,
  output logic        [$clog2(FIFO_DEPTH):0]  ov_level,
  output logic                                o_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DECIM - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic signed [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic        [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic        [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic        [LVL_W-1:0]      level_q, level_d;
  logic        [PH_W-1:0]       phase_q, phase_d;
  logic                         valid_q, valid_d;
  logic signed [DATA_WIDTH-1:0] data_q, data_d;
  logic                         ovf_q, ovf_d;
  logic                         keep_s, full_s, push_s, pop_s, drop_s;

  // Next-state logic for decimation, FIFO bookkeeping and the registered head.
  always_comb begin
    keep_s = i_sum_valid && (phase_q == '0);
    full_s = (level_q == LVL_FULL);
    pop_s  = (level_q != '0) && i_ready && !i_flush;
    push_s = keep_s && (!full_s || pop_s) && !i_flush;
    drop_s = keep_s && full_s && !pop_s && !i_flush;

    phase_d = phase_q;
    if (i_flush) begin
      phase_d = '0;
    end else if (i_sum_valid) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
    end else begin
      phase_d = phase_q;
    end

    wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // The new head may be the sample being written this very edge.
    if (i_flush) begin
      data_d = '0;
    end else if (level_d == '0) begin
      data_d = data_q;
    end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      data_d = iv_sum;
    end else begin
      data_d = mem_q[rd_ptr_d];
    end

    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_d;
      rd_ptr_d = rd_ptr_d;
      level_d  = level_d;
    end

    valid_d = (level_d != '0);

    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (i_clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      phase_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      phase_q  <= phase_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  // Sample storage; contents are qualified by the level, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= iv_sum;
    end
  end

  assign o_valid    = valid_q;
  assign ov_data    = data_q;
  assign ov_level   = level_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_fir_output_buffer.sv
// Scoreboard bench: two buffers (DECIM=1 and DECIM=3) share one stimulus stream and are
// each checked against a queue-based model of the decimating FIFO.
module tb_fir_output_buffer;

  localparam int DW    = 24;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 sv;
  logic signed [DW-1:0] sum;
  logic                 flush;
  logic                 clr;
  logic                 ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s inst%0d t=%0t: got %0d expected %0d", nm, inst, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int DEC = (g == 0) ? 1 : 3;
    logic                 valid;
    logic signed [DW-1:0] data;
    logic [LW-1:0]        level;
    logic                 ovf;

    fir_output_buffer #(.DATA_WIDTH(DW), .DECIM(DEC), .FIFO_DEPTH(DEPTH)) u_dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_sum_valid(sv),
      .iv_sum     (sum),
      .i_flush    (flush),
      .i_clr_ovf  (clr),
      .i_ready    (ready),
      .o_valid    (valid),
      .ov_data    (data),
      .ov_level   (level),
      .o_overflow (ovf)
    );

    logic signed [DW-1:0] q[$];
    int  cnt   = 0;
    bit  m_ovf = 1'b0;

    // Monitor: compare outputs to the model, then apply the inputs the next edge will see.
    always @(negedge clk) begin
      bit popping;
      bit full;
      bit drop;
      logic signed [DW-1:0] head;
      if (!rst_n) begin
        q.delete();
        cnt   = 0;
        m_ovf = 1'b0;
        chk("rst_valid", g, int'(valid), 0);
        chk("rst_level", g, int'(level), 0);
        chk("rst_data", g, int'(data), 0);
        chk("rst_ovf", g, int'(ovf), 0);
      end else begin
        chk("level", g, int'(level), q.size());
        chk("valid", g, int'(valid), int'(q.size() != 0));
        chk("overflow", g, int'(ovf), int'(m_ovf));
        drop = 1'b0;
        if (flush) begin
          q.delete();
          cnt = 0;
        end else begin
          popping = (q.size() != 0) && ready;
          full    = (q.size() == DEPTH);
          if (q.size() != 0) begin
            head = q[0];
            chk("data", g, int'(data), int'(head));
            if (popping) void'(q.pop_front());
          end
          if (sv && cnt == 0) begin
            if (!full || popping) q.push_back(sum);
            else drop = 1'b1;
          end
          if (sv) cnt = (cnt + 1) % DEC;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
      end
    end
  end

  task automatic step(input bit v, input int val, input bit rdy, input bit fl, input bit cl);
    sv    = v;
    sum   = DW'(val);
    ready = rdy;
    flush = fl;
    clr   = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    sv = 1'b0; sum = '0; flush = 1'b0; clr = 1'b0; ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Back-to-back pushes with a ready consumer.
    step(0, 0, 1, 1, 0);
    step(1, 5, 1, 0, 0);
    step(1, -3, 1, 0, 0);
    step(1, 7, 1, 0, 0);
    repeat (3) step(0, 0, 1, 0, 0);

    // Decimation of 1..9.
    step(0, 0, 1, 1, 0);
    for (int i = 1; i <= 9; i++) step(1, i, 1, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0);

    // Fill past full, clear flag, push into full with a pop, drain.
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 100 + i, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(1, 55, 1, 0, 0);
    repeat (12) step(0, 0, 1, 0, 0);

    // Flush at level 4, then a fresh sample.
    for (int i = 0; i < 4; i++) step(1, 20 + i, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    step(1, 42, 1, 0, 0);
    repeat (3) step(0, 0, 1, 0, 0);

    // Clear and drop on the same edge: the flag must stay set.
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) step(1, -50 - i, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(1, 2, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    repeat (10) step(0, 0, 1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step(bit'($urandom_range(0, 1)), int'($urandom()), bit'($urandom_range(0, 2) != 0),
           bit'($urandom_range(0, 39) == 0), bit'($urandom_range(0, 19) == 0));

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 5; i++) step(1, 300 + i, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 0, int'(g_inst[0].valid), 0);
    chk("async_level", 0, int'(g_inst[0].level), 0);
    chk("async_data", 0, int'(g_inst[0].data), 0);
    chk("async_valid", 1, int'(g_inst[1].valid), 0);
    chk("async_level", 1, int'(g_inst[1].level), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 150; i++)
      step(bit'($urandom_range(0, 1)), int'($urandom()), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 49) == 0), bit'($urandom_range(0, 19) == 0));
    repeat (12) step(0, 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
